// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the mesh router input-port logic:
//   - direction codes used as VC / output-port selects
//   - flit type codes carried in the two LSBs of every flit
//   - route-compute FSM state encoding
//   - small decode helpers for flit fields
// -----------------------------------------------------------------------------
package noc_pkg;

    // Direction codes (out_vc_select / route encoding)
    localparam logic [2:0] DIR_N       = 3'b000;
    localparam logic [2:0] DIR_S       = 3'b001;
    localparam logic [2:0] DIR_E       = 3'b010;
    localparam logic [2:0] DIR_W       = 3'b011;
    localparam logic [2:0] DIR_L       = 3'b100;
    localparam logic [2:0] DIR_INVALID = 3'b111;

    // Flit type codes, in_data[1:0]
    localparam logic [1:0] FLIT_SINGLE = 2'b00;
    localparam logic [1:0] FLIT_BODY   = 2'b01;
    localparam logic [1:0] FLIT_TAIL   = 2'b10;
    localparam logic [1:0] FLIT_HEAD   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUTED = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

    // Flit type sits in the two LSBs regardless of flit width.
    function automatic logic [1:0] flit_type_of(input logic [1:0] low_bits);
        return low_bits;
    endfunction

    // A single-flit packet is both head and tail.
    function automatic logic flit_is_head(input logic [1:0] ftype);
        return (ftype == FLIT_HEAD) || (ftype == FLIT_SINGLE);
    endfunction

    function automatic logic flit_is_tail(input logic [1:0] ftype);
        return (ftype == FLIT_TAIL) || (ftype == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/route_calc.sv
// -----------------------------------------------------------------------------
// route_calc
// Purely combinational dimension-ordered route computation with mesh-bounds
// and U-turn checking.
// Ports:
//   dest_x, dest_y : destination coordinates from the head flit
//   route          : direction code (N/S/E/W/L)
//   route_ok       : 1 when destination is inside the mesh and the route does
//                    not send the packet back out of the port it arrived on
// -----------------------------------------------------------------------------
module route_calc
    import noc_pkg::*;
#(
    parameter int         COORD_W   = 8,
    parameter int         MESH_X    = 4,
    parameter int         MESH_Y    = 4,
    parameter int         ALGORITHM = 0,
    parameter logic [2:0] PORT      = 3'b000,
    parameter int         ROUTER_X  = 0,
    parameter int         ROUTER_Y  = 0
) (
    input  logic [COORD_W-1:0] dest_x,
    input  logic [COORD_W-1:0] dest_y,
    output logic [2:0]         route,
    output logic               route_ok
);

    localparam logic [COORD_W-1:0] RX = COORD_W'(ROUTER_X);
    localparam logic [COORD_W-1:0] RY = COORD_W'(ROUTER_Y);
    localparam logic [31:0]        MX = 32'(MESH_X);
    localparam logic [31:0]        MY = 32'(MESH_Y);

    logic at_x;
    logic at_y;
    logic in_mesh;

    assign at_x    = (dest_x == RX);
    assign at_y    = (dest_y == RY);
    assign in_mesh = (32'(dest_x) < MX) && (32'(dest_y) < MY);

    always_comb begin
        route = DIR_INVALID;
        if (at_x && at_y) begin
            route = DIR_L;
        end else if (ALGORITHM == 0) begin
            // XY: resolve X first, then Y
            if (at_x) begin
                route = (dest_y < RY) ? DIR_N : DIR_S;
            end else begin
                route = (dest_x > RX) ? DIR_E : DIR_W;
            end
        end else begin
            // YX: resolve Y first, then X
            if (at_y) begin
                route = (dest_x < RX) ? DIR_W : DIR_E;
            end else begin
                route = (dest_y > RY) ? DIR_S : DIR_N;
            end
        end
    end

    assign route_ok = in_mesh && (route != PORT);

endmodule

// File: rtl/route_compute_unit.sv
// -----------------------------------------------------------------------------
// route_compute_unit
// Per-input-port route computation stage with one registered valid/ready
// output slot and wormhole route locking. The head flit computes a route,
// body/tail flits reuse it, the tail releases it. Packets whose head has an
// invalid route are discarded whole and counted.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   in_data/in_valid  : incoming flit, in_ready = accepted this cycle
//   out_data          : registered flit
//   out_vc_select     : locked route direction code (111 after reset)
//   out_head/out_tail : flit framing of out_data
//   out_valid/out_ready : output handshake
//   drop_pulse        : one cycle after a packet is discarded
//   proto_err         : one cycle after an out-of-protocol flit is discarded
//   drop_count        : saturating count of dropped packets
// -----------------------------------------------------------------------------
module route_compute_unit
    import noc_pkg::*;
#(
    parameter int         DSIZE     = 32,
    parameter int         COORD_W   = 8,
    parameter int         MESH_X    = 4,
    parameter int         MESH_Y    = 4,
    parameter int         ALGORITHM = 0,
    parameter logic [2:0] PORT      = 3'b000,
    parameter int         ROUTER_X  = 0,
    parameter int         ROUTER_Y  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DSIZE-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DSIZE-1:0] out_data,
    output logic [2:0]       out_vc_select,
    output logic             out_head,
    output logic             out_tail,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             drop_pulse,
    output logic             proto_err,
    output logic [7:0]       drop_count
);

    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
    logic [1:0]         ftype;
    logic [2:0]         route;
    logic               route_ok;
    logic               accept;

    state_t     state_q, state_d;
    logic [2:0] lock_route;

    logic       load;
    logic [2:0] load_route;
    logic       load_head;
    logic       load_tail;
    logic       drop_evt;
    logic       proto_evt;

    assign dest_x = in_data[DSIZE-1 -: COORD_W];
    assign dest_y = in_data[DSIZE-1-COORD_W -: COORD_W];
    assign ftype  = flit_type_of(in_data[1:0]);

    // Dropped flits drain through the same handshake as forwarded ones.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    route_calc #(
        .COORD_W   (COORD_W),
        .MESH_X    (MESH_X),
        .MESH_Y    (MESH_Y),
        .ALGORITHM (ALGORITHM),
        .PORT      (PORT),
        .ROUTER_X  (ROUTER_X),
        .ROUTER_Y  (ROUTER_Y)
    ) u_route_calc (
        .dest_x   (dest_x),
        .dest_y   (dest_y),
        .route    (route),
        .route_ok (route_ok)
    );

    // Next-state and per-flit action decode
    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        load_route = lock_route;
        load_head  = 1'b0;
        load_tail  = 1'b0;
        drop_evt   = 1'b0;
        proto_evt  = 1'b0;
        if (accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ftype == FLIT_HEAD) begin
                        if (route_ok) begin
                            load       = 1'b1;
                            load_route = route;
                            load_head  = 1'b1;
                            state_d    = ST_ROUTED;
                        end else begin
                            drop_evt = 1'b1;
                            state_d  = ST_DROP;
                        end
                    end else if (ftype == FLIT_SINGLE) begin
                        if (route_ok) begin
                            load       = 1'b1;
                            load_route = route;
                            load_head  = flit_is_head(ftype);
                            load_tail  = flit_is_tail(ftype);
                        end else begin
                            drop_evt = 1'b1;
                        end
                    end else begin
                        proto_evt = 1'b1;
                    end
                end
                ST_ROUTED: begin
                    if (ftype == FLIT_BODY) begin
                        load = 1'b1;
                    end else if (ftype == FLIT_TAIL) begin
                        load      = 1'b1;
                        load_tail = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        proto_evt = 1'b1;
                    end
                end
                ST_DROP: begin
                    if (ftype == FLIT_TAIL) begin
                        state_d = ST_IDLE;
                    end else if (ftype != FLIT_BODY) begin
                        proto_evt = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output register, route lock, event pulses and drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            lock_route    <= DIR_INVALID;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_vc_select <= DIR_INVALID;
            out_head      <= 1'b0;
            out_tail      <= 1'b0;
            drop_pulse    <= 1'b0;
            proto_err     <= 1'b0;
            drop_count    <= 8'd0;
        end else begin
            state_q <= state_d;
            if (load) begin
                // Also covers dequeue+enqueue in one cycle: overwrite, no bubble.
                out_valid     <= 1'b1;
                out_data      <= in_data;
                out_vc_select <= load_route;
                out_head      <= load_head;
                out_tail      <= load_tail;
                lock_route    <= load_route;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            drop_pulse <= drop_evt;
            proto_err  <= proto_evt;
            if (drop_evt && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_route_compute_unit.sv
module tb_route_compute_unit;
    import noc_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [2:0]  out_vc_select;
    logic        out_head;
    logic        out_tail;
    logic        out_valid;
    logic        out_ready;
    logic        drop_pulse;
    logic        proto_err;
    logic [7:0]  drop_count;

    logic [31:0] yx_in_data;
    logic        yx_in_valid;
    logic        yx_in_ready;
    logic [31:0] yx_out_data;
    logic [2:0]  yx_out_vc_select;
    logic        yx_out_head;
    logic        yx_out_tail;
    logic        yx_out_valid;
    logic        yx_drop_pulse;
    logic        yx_proto_err;
    logic [7:0]  yx_drop_count;

    int checks = 0;
    int errors = 0;

    route_compute_unit #(
        .DSIZE(32), .COORD_W(8), .MESH_X(4), .MESH_Y(4), .ALGORITHM(0),
        .PORT(3'b000), .ROUTER_X(1), .ROUTER_Y(1)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_vc_select(out_vc_select),
        .out_head(out_head), .out_tail(out_tail), .out_valid(out_valid),
        .out_ready(out_ready), .drop_pulse(drop_pulse), .proto_err(proto_err),
        .drop_count(drop_count)
    );

    route_compute_unit #(
        .DSIZE(32), .COORD_W(8), .MESH_X(4), .MESH_Y(4), .ALGORITHM(1),
        .PORT(3'b000), .ROUTER_X(1), .ROUTER_Y(1)
    ) dut_yx (
        .clk(clk), .reset(reset), .in_data(yx_in_data), .in_valid(yx_in_valid),
        .in_ready(yx_in_ready), .out_data(yx_out_data), .out_vc_select(yx_out_vc_select),
        .out_head(yx_out_head), .out_tail(yx_out_tail), .out_valid(yx_out_valid),
        .out_ready(1'b1), .drop_pulse(yx_drop_pulse), .proto_err(yx_proto_err),
        .drop_count(yx_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input int x, input int y, input logic [1:0] t, input int tag);
        return {8'(x), 8'(y), 14'(tag), t};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        yx_in_valid = 1'b0;
        yx_in_data  = '0;
        #2;
        // Reset values
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_vc", 32'(out_vc_select), 32'd7);
        check("rst_head", 32'(out_head), 32'd0);
        check("rst_tail", 32'(out_tail), 32'd0);
        check("rst_drop_pulse", 32'(drop_pulse), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        reset = 1'b0;

        // XY forwarding: head (3,1) -> E, body, tail
        in_valid = 1'b1;
        in_data  = mk(3, 1, FLIT_HEAD, 1);
        tick();
        check("xy_head_valid", 32'(out_valid), 32'd1);
        check("xy_head_data", out_data, mk(3, 1, FLIT_HEAD, 1));
        check("xy_head_vc", 32'(out_vc_select), 32'(DIR_E));
        check("xy_head_flag", 32'({out_head, out_tail}), 32'b10);
        in_data = mk(0, 0, FLIT_BODY, 2);
        tick();
        check("xy_body_data", out_data, mk(0, 0, FLIT_BODY, 2));
        check("xy_body_vc", 32'(out_vc_select), 32'(DIR_E));
        check("xy_body_flag", 32'({out_head, out_tail}), 32'b00);
        in_data = mk(0, 0, FLIT_TAIL, 3);
        tick();
        check("xy_tail_data", out_data, mk(0, 0, FLIT_TAIL, 3));
        check("xy_tail_vc", 32'(out_vc_select), 32'(DIR_E));
        check("xy_tail_flag", 32'({out_head, out_tail}), 32'b01);
        check("xy_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        in_valid = 1'b0;
        tick();
        check("xy_drained", 32'(out_valid), 32'd0);

        // Dimension order: head (0,2): XY -> W, YX -> S
        in_valid    = 1'b1;
        in_data     = mk(0, 2, FLIT_HEAD, 4);
        yx_in_valid = 1'b1;
        yx_in_data  = mk(0, 2, FLIT_HEAD, 4);
        tick();
        check("xy_vc_w", 32'(out_vc_select), 32'(DIR_W));
        check("yx_vc_s", 32'(yx_out_vc_select), 32'(DIR_S));
        check("yx_valid", 32'(yx_out_valid), 32'd1);
        in_data    = mk(0, 0, FLIT_TAIL, 5);
        yx_in_data = mk(0, 0, FLIT_TAIL, 5);
        tick();
        check("xy_w_tail_vc", 32'(out_vc_select), 32'(DIR_W));
        check("yx_s_tail_vc", 32'(yx_out_vc_select), 32'(DIR_S));
        yx_in_valid = 1'b0;

        // U-turn: head (1,0) routes N back out the N port
        in_data = mk(1, 0, FLIT_HEAD, 6);
        tick();
        check("ut_head_valid", 32'(out_valid), 32'd0);
        check("ut_drop_pulse", 32'(drop_pulse), 32'd1);
        check("ut_drop_count", 32'(drop_count), 32'd1);
        in_data = mk(0, 0, FLIT_BODY, 7);
        tick();
        check("ut_body_valid", 32'(out_valid), 32'd0);
        check("ut_pulse_once", 32'(drop_pulse), 32'd0);
        check("ut_body_no_perr", 32'(proto_err), 32'd0);
        in_data = mk(0, 0, FLIT_TAIL, 8);
        tick();
        check("ut_tail_valid", 32'(out_valid), 32'd0);
        check("ut_tail_count", 32'(drop_count), 32'd1);
        in_data = mk(1, 1, FLIT_HEAD, 9);
        tick();
        check("local_valid", 32'(out_valid), 32'd1);
        check("local_vc", 32'(out_vc_select), 32'(DIR_L));
        check("local_data", out_data, mk(1, 1, FLIT_HEAD, 9));
        in_data = mk(0, 0, FLIT_TAIL, 10);
        tick();
        check("local_tail_vc", 32'(out_vc_select), 32'(DIR_L));

        // Out of mesh: single-flit packet to (4,1)
        in_data = mk(4, 1, FLIT_SINGLE, 11);
        tick();
        check("oom_valid", 32'(out_valid), 32'd0);
        check("oom_drop_pulse", 32'(drop_pulse), 32'd1);
        check("oom_drop_count", 32'(drop_count), 32'd2);
        check("oom_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        // Valid single-flit packet: head and tail together
        in_data = mk(2, 3, FLIT_SINGLE, 12);
        tick();
        check("single_vc", 32'(out_vc_select), 32'(DIR_E));
        check("single_flag", 32'({out_head, out_tail}), 32'b11);
        in_valid = 1'b0;
        tick();

        // Backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = mk(3, 1, FLIT_HEAD, 16);
        tick();
        check("bp_load_valid", 32'(out_valid), 32'd1);
        in_data = mk(0, 0, FLIT_BODY, 17);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_data", out_data, mk(3, 1, FLIT_HEAD, 16));
            check("bp_hold_vc", 32'(out_vc_select), 32'(DIR_E));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_body_data", out_data, mk(0, 0, FLIT_BODY, 17));
        in_data = mk(0, 0, FLIT_TAIL, 18);
        tick();
        check("bp_tail_data", out_data, mk(0, 0, FLIT_TAIL, 18));
        check("bp_tail_flag", 32'(out_tail), 32'd1);
        in_valid = 1'b0;
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Drop counter saturation
        in_valid = 1'b1;
        for (int i = 0; i < 260; i++) begin
            in_data = mk(4, 1, FLIT_SINGLE, i);
            tick();
        end
        check("sat_count", 32'(drop_count), 32'd255);
        check("sat_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        tick();
        check("sat_pulse_end", 32'(drop_pulse), 32'd0);

        // Reset mid-packet
        in_valid = 1'b1;
        in_data  = mk(3, 1, FLIT_HEAD, 20);
        tick();
        check("mid_head_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_vc", 32'(out_vc_select), 32'd7);
        check("mid_rst_count", 32'(drop_count), 32'd0);
        reset = 1'b0;
        #1;
        in_valid = 1'b1;
        in_data  = mk(0, 0, FLIT_BODY, 21);
        tick();
        check("mid_body_perr", 32'(proto_err), 32'd1);
        check("mid_body_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        tick();
        check("mid_perr_once", 32'(proto_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/route_compute_unit.md
# route_compute_unit

Per-input-port route computation stage for the mesh router, successor to the single-flit combinational router. It adds a registered valid/ready pipeline stage, wormhole route locking (head computes, body/tail reuse, tail releases), selectable XY/YX dimension order, and mesh-bounds checking. Invalid packets are dropped whole and counted. It sits between each input port's receive logic and the VC buffer / switch-allocation stage.

## Interface
- `DSIZE`, 32, flit width in bits.
- `COORD_W`, 8, width of each destination coordinate field. Requires `DSIZE >= 2*COORD_W+2`.
- `MESH_X`, 4, mesh columns. Valid x range is 0..MESH_X-1.
- `MESH_Y`, 4, mesh rows. Valid y range is 0..MESH_Y-1.
- `ALGORITHM`, 0, dimension order: 0 = XY, 1 = YX.
- `PORT`, 3'b000, direction code of the input port this unit serves.
- `ROUTER_X`, 0, this router's x coordinate.
- `ROUTER_Y`, 0, this router's y coordinate.

Ports (clock and reset first):
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `in_data` input DSIZE: flit. Fields:
  - `[DSIZE-1 -: COORD_W]` = dest_x.
  - next COORD_W bits = dest_y.
  - `[1:0]` = flit type.
- `in_valid` input 1: flit present.
- `in_ready` output 1: flit accepted when in_valid && in_ready.
- `out_data` output DSIZE: registered flit.
- `out_vc_select` output 3: locked route. Codes: N=000, S=001, E=010, W=011, L=100.
- `out_head` output 1: out_data is a head flit (type 11 or 00).
- `out_tail` output 1: out_data is a tail flit (type 10 or 00).
- `out_valid` output 1: output register holds a flit.
- `out_ready` input 1: downstream accepts.
- `drop_pulse` output 1: one-cycle pulse when a packet is discarded.
- `proto_err` output 1: one-cycle pulse when an out-of-protocol flit is discarded.
- `drop_count` output 8: count of dropped packets, saturating at 255.

## Operation
- Flit types:
  - 11 = head.
  - 01 = body.
  - 10 = tail.
  - 00 = single-flit packet (head and tail).
- States:
  - IDLE: waiting for a head.
  - ROUTED: route locked, forwarding body/tail flits.
  - DROP: discarding the rest of a packet.
- Route calculation, XY: if dest == (ROUTER_X, ROUTER_Y) then L. Else if dest_x == ROUTER_X then N when dest_y < ROUTER_Y, otherwise S. Else E when dest_x > ROUTER_X, otherwise W.
- Route calculation, YX: if dest == (ROUTER_X, ROUTER_Y) then L. Else if dest_y == ROUTER_Y then W when dest_x < ROUTER_X, otherwise E. Else S when dest_y > ROUTER_Y, otherwise N.
- All coordinate comparisons are unsigned.
- A route is invalid if route == PORT (U-turn), dest_x >= MESH_X, or dest_y >= MESH_Y.
- IDLE, accepted flit:
  - Head 11 with valid route: load output register, latch route, go to ROUTED.
  - Head 11 with invalid route: not forwarded; pulse drop_pulse, increment drop_count, go to DROP.
  - Type 00 with valid route: forward with head=tail=1, stay in IDLE.
  - Type 00 with invalid route: drop and count, stay in IDLE.
  - Body or tail: discard, pulse proto_err.
- ROUTED, accepted flit:
  - Body: forward with the latched route.
  - Tail: forward with the latched route, go to IDLE.
  - Head or 00: discard, pulse proto_err, stay in ROUTED.
- DROP, accepted flit:
  - Body: discard silently.
  - Tail: discard silently, go to IDLE.
  - Head or 00: discard, pulse proto_err.
- Discarded flits never load the output register.

## Timing
- Reset values: out_valid=0, out_data=0, out_vc_select=3'b111, out_head=0, out_tail=0, drop_pulse=0, proto_err=0, drop_count=0, state=IDLE.
- in_ready = !out_valid || out_ready, in every state. Dropped flits use the same handshake.
- Latency: a flit accepted at edge k appears with out_valid=1 after edge k. Full throughput is one flit per cycle.
- Backpressure: while out_valid && !out_ready, all out_* fields are held stable.
- Simultaneous dequeue and enqueue in the same cycle: the register is overwritten, with no bubble.
- drop_pulse and proto_err are registered. Each is high for exactly the cycle after the offending acceptance.
- drop_count saturates at 255 and does not wrap.
- Reset mid-packet: all state clears immediately and the packet in flight is abandoned. Body/tail flits that arrive afterwards are protocol errors.

## Structure
- Shared package `noc_pkg` holds:
  - Direction codes N/S/E/W/L/INVALID.
  - Flit type codes.
  - State enum.
  - Helper functions for field extraction.
- Sub-module `route_calc` is purely combinational. It takes dest_x, dest_y and the parameters, and outputs route[2:0] and route_ok.
- The top level holds the FSM, the output register and the counter.

## Test plan
All scenarios use ROUTER=(1,1), MESH 4x4, PORT=N (000) unless noted.
- XY forwarding: head dest (3,1), then body, then tail. Required: three outputs on consecutive cycles with vc=010; out_head on the first, out_tail on the last; state returns to IDLE.
- YX order: ALGORITHM=1, head dest (0,2). Required: vc=001 (S). The same stimulus with ALGORITHM=0 gives 011 (W).
- U-turn: head dest (1,0), then body, then tail. Required: no out_valid; one drop_pulse; drop_count=1; the next valid head to (1,1) is forwarded with vc=100.
- Out of mesh: single-flit packet (type 00) to dest (4,1). Required: dropped, drop_count increments, state stays IDLE.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1. Required: out_data and out_vc_select stable, in_ready=0; after release, one transfer per cycle with no lost or duplicated flit.
- Reset mid-packet: head to E accepted, then reset. Required: all outputs at reset values; a following body flit gives a proto_err pulse and no out_valid.
